// File: rtl/agu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agu_pkg                                                                    |
// | Shared op-size encodings, NOP opcode and queue entry layout for the AGU.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package agu_pkg;

    localparam int AGU_XLEN  = 32;
    localparam int AGU_OP_W  = 5;
    localparam int AGU_TAG_W = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [AGU_OP_W-1:0] OP_NOP = '1;

    typedef struct packed {
        logic [AGU_XLEN-1:0]  addr;
        logic [AGU_OP_W-1:0]  op;
        logic [AGU_TAG_W-1:0] tag;
        logic [AGU_XLEN-1:0]  data;
        logic                 misalign;
    } agu_entry_t;

    // Only the low two address bits matter for byte/half/word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = addr_lo[0];
            SZ_W:    r = (addr_lo != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agu_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agu_fifo                                                                   |
// | Generic synchronous first-word-fall-through FIFO with flush and hold.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module agu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     hold,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    // Hold freezes everything; overflow/underflow requests are ignored here too.
    assign w_push = push & ~hold & (r_count != c_FULL);
    assign w_pop  = pop  & ~hold & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/agu_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agu_queue                                                                  |
// | Address-generation unit (base+offset) feeding a FWFT result queue.         |
// | Optional: define AGU_MISALIGN_EN to store and present a misalign flag.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module agu_queue
    import agu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OP_W  = 5,
    parameter int TAG_W = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_base,
    input  logic [XLEN-1:0]  in_offset,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_addr,
    output logic [OP_W-1:0]  out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_data,
    output logic             out_misalign
);

`ifdef AGU_MISALIGN_EN
    localparam int c_MIS_W = 1;
`else
    localparam int c_MIS_W = 0;
`endif
    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_ENTRY_W = XLEN + OP_W + TAG_W + XLEN + c_MIS_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [XLEN-1:0]      w_addr;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_push;
    logic                 w_pop;
    logic [XLEN-1:0]      w_head_addr;
    logic [OP_W-1:0]      w_head_op;
    logic [TAG_W-1:0]     w_head_tag;
    logic [XLEN-1:0]      w_head_data;
    logic                 w_head_mis;

    // Carry out of the adder is intentionally dropped: addresses wrap mod 2^XLEN.
    assign w_addr = in_base + in_offset;

`ifdef AGU_MISALIGN_EN
    logic w_push_mis;
    assign w_push_mis   = is_misaligned(in_op[1:0], w_addr[1:0]);
    assign w_push_entry = {w_addr, in_op, in_tag, in_data, w_push_mis};
    assign {w_head_addr, w_head_op, w_head_tag, w_head_data, w_head_mis} = w_head_entry;
`else
    assign w_push_entry = {w_addr, in_op, in_tag, in_data};
    assign {w_head_addr, w_head_op, w_head_tag, w_head_data} = w_head_entry;
    assign w_head_mis   = 1'b0;
`endif

    // Readiness ignores out_ready, so a full queue never accepts in a pop cycle.
    assign in_ready  = rst & ~pause & ~flush & (w_count != c_FULL);
    assign out_valid = rst & ~pause & (w_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    agu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (pause),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_push_entry),
        .pop_data  (w_head_entry),
        .count     (w_count)
    );

    assign out_addr     = out_valid ? w_head_addr : '0;
    assign out_op       = out_valid ? w_head_op   : {OP_W{OP_NOP[0]}};
    assign out_tag      = out_valid ? w_head_tag  : '0;
    assign out_data     = out_valid ? w_head_data : '0;
    assign out_misalign = out_valid & w_head_mis;

endmodule
`default_nettype wire

// File: tb/tb_agu_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_agu_queue                                                               |
// | Self-checking bench: queue-based reference model plus directed literals.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_agu_queue;
    import agu_pkg::*;

    localparam int XLEN  = 32;
    localparam int OP_W  = 5;
    localparam int TAG_W = 3;
    localparam int DEPTH = 4;
`ifdef AGU_MISALIGN_EN
    localparam bit MIS_ON = 1'b1;
`else
    localparam bit MIS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pause = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_base = '0;
    logic [XLEN-1:0]  in_offset = '0;
    logic [OP_W-1:0]  in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [XLEN-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_addr;
    logic [OP_W-1:0]  out_op;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_data;
    logic             out_misalign;

    int vectors = 0;
    int miscompares = 0;
    agu_entry_t q[$];

    always #5 clk = ~clk;

    agu_queue #(.XLEN(XLEN), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_offset(in_offset), .in_op(in_op),
        .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_op(out_op), .out_tag(out_tag),
        .out_data(out_data), .out_misalign(out_misalign)
    );

    function automatic logic model_mis(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a);
        if (!MIS_ON) return 1'b0;
        if (op[1:0] == 2'b01) return a[0];
        if (op[1:0] == 2'b10) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        bit ov;
        ov = rst && !pause && (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(rst && !pause && !flush && (q.size() < DEPTH)));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_addr", out_addr, ov ? q[0].addr : 32'h0);
        chk("out_op", 32'(out_op), ov ? 32'(q[0].op) : 32'h1f);
        chk("out_tag", 32'(out_tag), ov ? 32'(q[0].tag) : 32'h0);
        chk("out_data", out_data, ov ? q[0].data : 32'h0);
        chk("out_misalign", 32'(out_misalign), ov ? 32'(q[0].misalign) : 32'h0);
    endtask

    // Drive at the negedge, then sample 1 time unit later against the model.
    task automatic apply(input logic v, input logic [31:0] base, input logic [31:0] off,
                         input logic [4:0] op, input logic [2:0] tag, input logic [31:0] data,
                         input logic ordy, input logic p, input logic f, input logic r);
        in_valid = v; in_base = base; in_offset = off; in_op = op; in_tag = tag;
        in_data = data; out_ready = ordy; pause = p; flush = f; rst = r;
        #1;
        compare_outputs();
    endtask

    task automatic tick();
        bit do_push, do_pop;
        agu_entry_t e;
        do_push = in_valid && rst && !pause && !flush && (q.size() < DEPTH);
        do_pop  = out_ready && rst && !pause && (q.size() != 0);
        e.addr = in_base + in_offset;
        e.op = in_op; e.tag = in_tag; e.data = in_data;
        e.misalign = model_mis(in_op, e.addr);
        @(posedge clk);
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic push1(input logic [2:0] tag, input logic [31:0] base, input logic [31:0] off,
                         input logic [4:0] op, input logic ordy);
        apply(1'b1, base, off, op, tag, $urandom, ordy, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic idle(input logic ordy, input logic p);
        apply(1'b0, $urandom, $urandom, 5'(($urandom)), 3'(($urandom)), $urandom, ordy, p, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        // Reset held for two edges; outputs must show the idle/NOP pattern.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'h10, 32'h20, 5'h2, 3'h1, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("rst_out_op", 32'(out_op), 32'h1f);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            tick();
        end

        // Single push, one-cycle latency, empty after the pop.
        apply(1'b1, 32'h1000, 32'h24, 5'h2, 3'd5, 32'hcafe_0001, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle(1'b1, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_addr", out_addr, 32'h1024);
        chk("t1_tag", 32'(out_tag), 32'h5);
        tick();
        idle(1'b1, 1'b0);
        chk("t1_empty", 32'(out_valid), 32'h0);
        tick();

        // Fill to DEPTH with backpressure, then a single pop frees one slot.
        for (int i = 0; i < DEPTH; i++) push1(3'(i), 32'h2000, 32'(i * 4), 5'h2, 1'b0);
        apply(1'b1, 32'h3000, 32'h0, 5'h2, 3'd7, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_full_ready", 32'(in_ready), 32'h0);
        tick();
        idle(1'b0, 1'b0);
        chk("t2_ready_again", 32'(in_ready), 32'h1);
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            idle(1'b1, 1'b0);
            chk("t2_order", 32'(out_tag), 32'(i));
            tick();
        end

        // Streaming: push and pop every cycle, tags wrap 0..7.
        for (int i = 0; i < 21; i++) begin
            apply(1'b1, $urandom, $urandom, 5'h0, 3'(i % 8), $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
            if (i > 0) chk("t3_stream_tag", 32'(out_tag), 32'((i - 1) % 8));
            tick();
        end
        idle(1'b1, 1'b0);
        tick();

        // Flush with a request offered: nothing survives, request dropped.
        for (int i = 0; i < 3; i++) push1(3'(i), 32'h4000, 32'h0, 5'h0, 1'b0);
        apply(1'b1, 32'h5000, 32'h4, 5'h2, 3'd6, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_flush_ready", 32'(in_ready), 32'h0);
        tick();
        idle(1'b1, 1'b0);
        chk("t4_after_flush", 32'(out_valid), 32'h0);
        tick();

        // Pause for three cycles with two entries queued.
        push1(3'd2, 32'h6000, 32'h0, 5'h0, 1'b0);
        push1(3'd3, 32'h6000, 32'h8, 5'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b1);
            chk("t5_paused_valid", 32'(out_valid), 32'h0);
            tick();
        end
        idle(1'b1, 1'b0);
        chk("t5_first", 32'(out_tag), 32'h2);
        tick();
        idle(1'b1, 1'b0);
        chk("t5_second", out_addr, 32'h6008);
        tick();

        // Alignment cases and address wrap.
        push1(3'd0, 32'h1000, 32'h2, 5'h2, 1'b0);
        push1(3'd1, 32'h1000, 32'h1, 5'h1, 1'b0);
        push1(3'd2, 32'h1000, 32'h3, 5'h0, 1'b0);
        push1(3'd3, 32'hFFFF_FFFC, 32'h8, 5'h2, 1'b0);
        idle(1'b1, 1'b0);
        chk("t6_word_mis", 32'(out_misalign), 32'(MIS_ON));
        tick();
        idle(1'b1, 1'b0);
        chk("t6_half_mis", 32'(out_misalign), 32'(MIS_ON));
        tick();
        idle(1'b1, 1'b0);
        chk("t6_byte_mis", 32'(out_misalign), 32'h0);
        tick();
        idle(1'b1, 1'b0);
        chk("t6_wrap_addr", out_addr, 32'h4);
        tick();

        // Randomized traffic with occasional pause, flush and reset.
        for (int i = 0; i < 500; i++) begin
            apply($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom), 3'($urandom),
                  $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 59) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
